mod_morse_sequencer: RTL and testbench

//  Consumes the debounced button level btn_db and the character selector letter.
//  On each new press it plays the International Morse pattern for the latched character on morse_out (LED/buzzer).
//  It then returns a one-cycle done pulse to the debouncer's done input, which lets the debouncer release btn_db.

---
 rtl/mod_morse_sequencer.sv | 241 ++++++++++++++++++++++++
 tb/tb_mod_morse_sequencer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_morse_sequencer.sv
// -----------------------------------------------------------------------------
// mod_morse_sequencer
//
// Plays the International Morse pattern of a latched character on morse_out
// each time the debounced button level (start) rises, then returns a
// one-cycle done pulse so the upstream debouncer can release its held level.
//
// Parameters:
//   UNIT_CYCLES : clk cycles per Morse time unit (>=1). dot = 1 unit,
//                 dash = 3 units, intra-character space = 1 unit,
//                 inter-character gap = 3 units.
//
// Ports:
//   clk        in   system clock, all logic on posedge
//   rst        in   synchronous reset, active-high
//   start      in   debounced press level; a rising edge seen in IDLE starts
//                   a sequence
//   letter     in   [5:0] character code, 0..25 = A..Z, 26..35 = digits 0..9
//                   (digits only when MORSE_DIGITS_EN is defined)
//   morse_out  out  1 = mark (tone/LED on), 0 = space
//   busy       out  high from LOAD through DONE
//   done       out  one-cycle pulse at end of sequence or on an invalid code
//
// Build option:
//   MORSE_DIGITS_EN : when defined, codes 26..35 play digits 0..9. When
//                     undefined, codes 26..63 are treated as invalid and the
//                     digit ROM rows are not built.
// -----------------------------------------------------------------------------
module mod_morse_sequencer #(
  parameter int UNIT_CYCLES = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [5:0] letter,
  output logic       morse_out,
  output logic       busy,
  output logic       done
);

  // Counter must hold the longest duration (3 units) plus a sign-free margin.
  localparam int CW = $clog2(3 * UNIT_CYCLES) + 1;
  localparam logic [CW-1:0] DUR_1U = CW'(UNIT_CYCLES);
  localparam logic [CW-1:0] DUR_3U = CW'(3 * UNIT_CYCLES);
  localparam logic [CW-1:0] ONE    = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_MARK,
    S_SPACE,
    S_CGAP,
    S_DONE
  } state_t;

  // Character ROM: returns {len[2:0], pat[4:0]}. The pattern sits in the
  // low len bits and is played MSB-first; 1 = dash, 0 = dot. len = 0 marks
  // an invalid code.
  function automatic logic [7:0] rom_lookup(input logic [5:0] code);
    logic [7:0] r;
    r = 8'd0;
    case (code)
      6'd0:  r = {3'd2, 5'b00001}; // A .-
      6'd1:  r = {3'd4, 5'b01000}; // B -...
      6'd2:  r = {3'd4, 5'b01010}; // C -.-.
      6'd3:  r = {3'd3, 5'b00100}; // D -..
      6'd4:  r = {3'd1, 5'b00000}; // E .
      6'd5:  r = {3'd4, 5'b00010}; // F ..-.
      6'd6:  r = {3'd3, 5'b00110}; // G --.
      6'd7:  r = {3'd4, 5'b00000}; // H ....
      6'd8:  r = {3'd2, 5'b00000}; // I ..
      6'd9:  r = {3'd4, 5'b00111}; // J .---
      6'd10: r = {3'd3, 5'b00101}; // K -.-
      6'd11: r = {3'd4, 5'b00100}; // L .-..
      6'd12: r = {3'd2, 5'b00011}; // M --
      6'd13: r = {3'd2, 5'b00010}; // N -.
      6'd14: r = {3'd3, 5'b00111}; // O ---
      6'd15: r = {3'd4, 5'b00110}; // P .--.
      6'd16: r = {3'd4, 5'b01101}; // Q --.-
      6'd17: r = {3'd3, 5'b00010}; // R .-.
      6'd18: r = {3'd3, 5'b00000}; // S ...
      6'd19: r = {3'd1, 5'b00001}; // T -
      6'd20: r = {3'd3, 5'b00001}; // U ..-
      6'd21: r = {3'd4, 5'b00001}; // V ...-
      6'd22: r = {3'd3, 5'b00011}; // W .--
      6'd23: r = {3'd4, 5'b01001}; // X -..-
      6'd24: r = {3'd4, 5'b01011}; // Y -.--
      6'd25: r = {3'd4, 5'b01100}; // Z --..
`ifdef MORSE_DIGITS_EN
      6'd26: r = {3'd5, 5'b11111}; // 0 -----
      6'd27: r = {3'd5, 5'b01111}; // 1 .----
      6'd28: r = {3'd5, 5'b00111}; // 2 ..---
      6'd29: r = {3'd5, 5'b00011}; // 3 ...--
      6'd30: r = {3'd5, 5'b00001}; // 4 ....-
      6'd31: r = {3'd5, 5'b00000}; // 5 .....
      6'd32: r = {3'd5, 5'b10000}; // 6 -....
      6'd33: r = {3'd5, 5'b11000}; // 7 --...
      6'd34: r = {3'd5, 5'b11100}; // 8 ---..
      6'd35: r = {3'd5, 5'b11110}; // 9 ----.
`endif
      default: r = 8'd0;
    endcase
    return r;
  endfunction

  // Left-justify the pattern so the next symbol is always bit 4.
  function automatic logic [4:0] align_pat(input logic [4:0] pat,
                                           input logic [2:0] len);
    logic [4:0] a;
    case (len)
      3'd1:    a = pat << 4;
      3'd2:    a = pat << 3;
      3'd3:    a = pat << 2;
      3'd4:    a = pat << 1;
      default: a = pat;
    endcase
    return a;
  endfunction

  function automatic logic [CW-1:0] mark_dur(input logic is_dash);
    return is_dash ? DUR_3U : DUR_1U;
  endfunction

  // Control state (reset)
  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          start_q;

  // Datapath state (loaded before use, not reset)
  logic [5:0]    code_q, code_nxt;
  logic [4:0]    sh, sh_nxt;
  logic [2:0]    rem, rem_nxt;

  logic [7:0]    rom;
  logic [2:0]    rom_len;
  logic [4:0]    rom_aligned;
  logic          expire;
  logic          trigger;

  assign rom         = rom_lookup(code_q);
  assign rom_len     = rom[7:5];
  assign rom_aligned = align_pat(rom[4:0], rom_len);
  assign expire      = (cnt == ONE);
  assign trigger     = start && !start_q;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt - ONE;
    code_nxt  = code_q;
    sh_nxt    = sh;
    rem_nxt   = rem;
    morse_out = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;

    case (state)
      S_IDLE: begin
        busy    = 1'b0;
        cnt_nxt = '0;
        if (trigger) begin
          state_nxt = S_LOAD;
          code_nxt  = letter;
          cnt_nxt   = ONE;
        end
      end

      S_LOAD: begin
        if (rom_len == 3'd0) begin
          state_nxt = S_DONE;
          cnt_nxt   = ONE;
        end else begin
          state_nxt = S_MARK;
          sh_nxt    = rom_aligned;
          rem_nxt   = rom_len;
          cnt_nxt   = mark_dur(rom_aligned[4]);
        end
      end

      S_MARK: begin
        morse_out = 1'b1;
        if (expire) begin
          rem_nxt = rem - 3'd1;
          if (rem > 3'd1) begin
            state_nxt = S_SPACE;
            cnt_nxt   = DUR_1U;
          end else begin
            state_nxt = S_CGAP;
            cnt_nxt   = DUR_3U;
          end
        end
      end

      S_SPACE: begin
        if (expire) begin
          // Next symbol is the one just below the current head.
          state_nxt = S_MARK;
          sh_nxt    = {sh[3:0], 1'b0};
          cnt_nxt   = mark_dur(sh[3]);
        end
      end

      S_CGAP: begin
        if (expire) begin
          state_nxt = S_DONE;
          cnt_nxt   = ONE;
        end
      end

      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end

      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // start_q resets high so a level held through reset cannot trigger.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      start_q <= 1'b1;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      start_q <= start;
    end
  end

  always_ff @(posedge clk) begin
    code_q <= code_nxt;
    sh     <= sh_nxt;
    rem    <= rem_nxt;
  end

endmodule

// File: tb/tb_mod_morse_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mod_morse_sequencer
//
// Directed bench for mod_morse_sequencer with UNIT_CYCLES = 4. Each scenario
// raises start once and records morse_out/busy/done on the falling edge of
// every following cycle (index k = 1 is the cycle right after the trigger
// edge, when the FSM is in LOAD). The recorded traces are compared against
// hand-computed cycle ranges.
// -----------------------------------------------------------------------------
module tb_mod_morse_sequencer;

  logic       clk;
  logic       rst;
  logic       start;
  logic [5:0] letter;
  logic       morse_out;
  logic       busy;
  logic       done;

  int checks;
  int failures;

  logic mo_tr [1:128];
  logic bz_tr [1:128];
  logic dn_tr [1:128];

  mod_morse_sequencer #(.UNIT_CYCLES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .letter    (letter),
    .morse_out (morse_out),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drop start for a cycle, raise it with the chosen letter, then record n
  // cycles. mode 1 disturbs letter/start mid-run, mode 2 pulses rst.
  task automatic run_seq(input logic [5:0] ltr, input int n, input int mode);
    @(negedge clk);
    start  = 1'b0;
    letter = ltr;
    @(negedge clk);
    start  = 1'b1;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      mo_tr[k] = morse_out;
      bz_tr[k] = busy;
      dn_tr[k] = done;
      if (mode == 1) begin
        if (k == 10) begin letter = 6'd4; start = 1'b0; end
        if (k == 20) start = 1'b1;
        if (k == 30) start = 1'b0;
        if (k == 40) start = 1'b1;
      end
      if (mode == 2) begin
        if (k == 12) rst = 1'b1;
        if (k == 13) rst = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    int bad;
    rst    = 1'b1;
    start  = 1'b1;
    letter = 6'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (morse_out !== 1'b0) begin
      failures++;
      $display("FAIL reset_morse got=%b want=0", morse_out);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_busy got=%b want=0", busy);
    end
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL reset_done got=%b want=0", done);
    end
    rst = 1'b0;
    bad = -1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if ((busy !== 1'b0 || done !== 1'b0) && bad < 0) bad = k;
    end
    checks++;
    if (bad >= 0) begin
      failures++;
      $display("FAIL held_start_no_trigger cycle=%0d got busy/done active want idle", bad);
    end
  endtask

  // T (-): mark 2..13, gap 14..25, done 26
  task automatic test_trigger_after_reset();
    int bm, bb, bd;
    logic gm, gb, gd, em, eb, ed, xm, xb, xd;
    bm = -1; bb = -1; bd = -1;
    gm = 0; gb = 0; gd = 0; xm = 0; xb = 0; xd = 0;
    run_seq(6'd19, 30, 0);
    for (int k = 1; k <= 30; k++) begin
      em = (k inside {[2:13]});
      eb = (k inside {[1:26]});
      ed = (k == 26);
      if (mo_tr[k] !== em && bm < 0) begin bm = k; gm = mo_tr[k]; xm = em; end
      if (bz_tr[k] !== eb && bb < 0) begin bb = k; gb = bz_tr[k]; xb = eb; end
      if (dn_tr[k] !== ed && bd < 0) begin bd = k; gd = dn_tr[k]; xd = ed; end
    end
    checks++;
    if (bm >= 0) begin failures++; $display("FAIL T_morse cycle=%0d got=%b want=%b", bm, gm, xm); end
    checks++;
    if (bb >= 0) begin failures++; $display("FAIL T_busy cycle=%0d got=%b want=%b", bb, gb, xb); end
    checks++;
    if (bd >= 0) begin failures++; $display("FAIL T_done cycle=%0d got=%b want=%b", bd, gd, xd); end
  endtask

  // E (.): mark 2..5, gap 6..17, done 18
  task automatic test_letter_e();
    int bm, bb, bd;
    logic gm, gb, gd, em, eb, ed, xm, xb, xd;
    bm = -1; bb = -1; bd = -1;
    gm = 0; gb = 0; gd = 0; xm = 0; xb = 0; xd = 0;
    run_seq(6'd4, 24, 0);
    for (int k = 1; k <= 24; k++) begin
      em = (k inside {[2:5]});
      eb = (k inside {[1:18]});
      ed = (k == 18);
      if (mo_tr[k] !== em && bm < 0) begin bm = k; gm = mo_tr[k]; xm = em; end
      if (bz_tr[k] !== eb && bb < 0) begin bb = k; gb = bz_tr[k]; xb = eb; end
      if (dn_tr[k] !== ed && bd < 0) begin bd = k; gd = dn_tr[k]; xd = ed; end
    end
    checks++;
    if (bm >= 0) begin failures++; $display("FAIL E_morse cycle=%0d got=%b want=%b", bm, gm, xm); end
    checks++;
    if (bb >= 0) begin failures++; $display("FAIL E_busy cycle=%0d got=%b want=%b", bb, gb, xb); end
    checks++;
    if (bd >= 0) begin failures++; $display("FAIL E_done cycle=%0d got=%b want=%b", bd, gd, xd); end
  endtask

  // A (.-): mark 2..5, space 6..9, mark 10..21, gap 22..33, done 34
  task automatic test_letter_a();
    int bm, bb, bd;
    logic gm, gb, gd, em, eb, ed, xm, xb, xd;
    bm = -1; bb = -1; bd = -1;
    gm = 0; gb = 0; gd = 0; xm = 0; xb = 0; xd = 0;
    run_seq(6'd0, 40, 0);
    for (int k = 1; k <= 40; k++) begin
      em = (k inside {[2:5], [10:21]});
      eb = (k inside {[1:34]});
      ed = (k == 34);
      if (mo_tr[k] !== em && bm < 0) begin bm = k; gm = mo_tr[k]; xm = em; end
      if (bz_tr[k] !== eb && bb < 0) begin bb = k; gb = bz_tr[k]; xb = eb; end
      if (dn_tr[k] !== ed && bd < 0) begin bd = k; gd = dn_tr[k]; xd = ed; end
    end
    checks++;
    if (bm >= 0) begin failures++; $display("FAIL A_morse cycle=%0d got=%b want=%b", bm, gm, xm); end
    checks++;
    if (bb >= 0) begin failures++; $display("FAIL A_busy cycle=%0d got=%b want=%b", bb, gb, xb); end
    checks++;
    if (bd >= 0) begin failures++; $display("FAIL A_done cycle=%0d got=%b want=%b", bd, gd, xd); end
  endtask

  // Invalid code: busy 1..2, done at 2, no mark.
  task automatic test_invalid(input logic [5:0] code);
    int bm, bb, bd;
    logic gm, gb, gd, eb, ed, xb, xd;
    bm = -1; bb = -1; bd = -1;
    gm = 0; gb = 0; gd = 0; xb = 0; xd = 0;
    run_seq(code, 10, 0);
    for (int k = 1; k <= 10; k++) begin
      eb = (k inside {[1:2]});
      ed = (k == 2);
      if (mo_tr[k] !== 1'b0 && bm < 0) begin bm = k; gm = mo_tr[k]; end
      if (bz_tr[k] !== eb && bb < 0) begin bb = k; gb = bz_tr[k]; xb = eb; end
      if (dn_tr[k] !== ed && bd < 0) begin bd = k; gd = dn_tr[k]; xd = ed; end
    end
    checks++;
    if (bm >= 0) begin failures++; $display("FAIL invalid%0d_morse cycle=%0d got=%b want=0", code, bm, gm); end
    checks++;
    if (bb >= 0) begin failures++; $display("FAIL invalid%0d_busy cycle=%0d got=%b want=%b", code, bb, gb, xb); end
    checks++;
    if (bd >= 0) begin failures++; $display("FAIL invalid%0d_done cycle=%0d got=%b want=%b", code, bd, gd, xd); end
  endtask

`ifdef MORSE_DIGITS_EN
  // Digit 0 (-----): marks of 12 separated by spaces of 4, gap 78..89, done 90
  task automatic test_digit_zero();
    int bm, bb, bd;
    logic gm, gb, gd, em, eb, ed, xm, xb, xd;
    bm = -1; bb = -1; bd = -1;
    gm = 0; gb = 0; gd = 0; xm = 0; xb = 0; xd = 0;
    run_seq(6'd26, 95, 0);
    for (int k = 1; k <= 95; k++) begin
      em = (k inside {[2:13], [18:29], [34:45], [50:61], [66:77]});
      eb = (k inside {[1:90]});
      ed = (k == 90);
      if (mo_tr[k] !== em && bm < 0) begin bm = k; gm = mo_tr[k]; xm = em; end
      if (bz_tr[k] !== eb && bb < 0) begin bb = k; gb = bz_tr[k]; xb = eb; end
      if (dn_tr[k] !== ed && bd < 0) begin bd = k; gd = dn_tr[k]; xd = ed; end
    end
    checks++;
    if (bm >= 0) begin failures++; $display("FAIL D0_morse cycle=%0d got=%b want=%b", bm, gm, xm); end
    checks++;
    if (bb >= 0) begin failures++; $display("FAIL D0_busy cycle=%0d got=%b want=%b", bb, gb, xb); end
    checks++;
    if (bd >= 0) begin failures++; $display("FAIL D0_done cycle=%0d got=%b want=%b", bd, gd, xd); end
  endtask
`endif

  // O (---) with letter/start disturbed mid-run and start held after done:
  // marks 2..13, 18..29, 34..45, gap 46..57, done 58 only.
  task automatic test_back_to_back();
    int bm, bb, bd;
    logic gm, gb, gd, em, eb, ed, xm, xb, xd;
    bm = -1; bb = -1; bd = -1;
    gm = 0; gb = 0; gd = 0; xm = 0; xb = 0; xd = 0;
    run_seq(6'd14, 80, 1);
    for (int k = 1; k <= 80; k++) begin
      em = (k inside {[2:13], [18:29], [34:45]});
      eb = (k inside {[1:58]});
      ed = (k == 58);
      if (mo_tr[k] !== em && bm < 0) begin bm = k; gm = mo_tr[k]; xm = em; end
      if (bz_tr[k] !== eb && bb < 0) begin bb = k; gb = bz_tr[k]; xb = eb; end
      if (dn_tr[k] !== ed && bd < 0) begin bd = k; gd = dn_tr[k]; xd = ed; end
    end
    checks++;
    if (bm >= 0) begin failures++; $display("FAIL O_morse cycle=%0d got=%b want=%b", bm, gm, xm); end
    checks++;
    if (bb >= 0) begin failures++; $display("FAIL O_busy cycle=%0d got=%b want=%b", bb, gb, xb); end
    checks++;
    if (bd >= 0) begin failures++; $display("FAIL O_done cycle=%0d got=%b want=%b", bd, gd, xd); end
  endtask

  // A with rst applied during the second (dash) mark: everything idle from
  // cycle 13, no done, held start must not retrigger.
  task automatic test_reset_mid();
    int bm, bb, bd;
    logic gm, gb, gd, em, eb, xm, xb;
    bm = -1; bb = -1; bd = -1;
    gm = 0; gb = 0; gd = 0; xm = 0; xb = 0;
    run_seq(6'd0, 50, 2);
    for (int k = 1; k <= 50; k++) begin
      em = (k inside {[2:5], [10:12]});
      eb = (k inside {[1:12]});
      if (mo_tr[k] !== em && bm < 0) begin bm = k; gm = mo_tr[k]; xm = em; end
      if (bz_tr[k] !== eb && bb < 0) begin bb = k; gb = bz_tr[k]; xb = eb; end
      if (dn_tr[k] !== 1'b0 && bd < 0) begin bd = k; gd = dn_tr[k]; end
    end
    checks++;
    if (bm >= 0) begin failures++; $display("FAIL rstmid_morse cycle=%0d got=%b want=%b", bm, gm, xm); end
    checks++;
    if (bb >= 0) begin failures++; $display("FAIL rstmid_busy cycle=%0d got=%b want=%b", bb, gb, xb); end
    checks++;
    if (bd >= 0) begin failures++; $display("FAIL rstmid_done cycle=%0d got=%b want=0", bd, gd); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    start    = 1'b0;
    letter   = 6'd0;
    test_reset();
    test_trigger_after_reset();
    test_letter_e();
    test_letter_a();
`ifdef MORSE_DIGITS_EN
    test_digit_zero();
    test_invalid(6'd40);
`else
    test_invalid(6'd30);
    test_invalid(6'd63);
`endif
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
